in_spike_collector: RTL and testbench
=====================================

IN_SPIKE_COLLECTOR -- requirements
Module: in_spike_collector

Interface
REQ-001 SHALL have parameter NUM_AXONS, default 256, number of axons per neuron core.
REQ-002 SHALL have parameter AXON_CNT_BIT_WIDTH, default 8, axon address width; NUM_AXONS == 1<<AXON_CNT_BIT_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, depth of the incoming-packet FIFO.
REQ-004 SHALL have the following ports: clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port pkt_valid_i  in  1  incoming spike packet valid.
REQ-007 SHALL have port pkt_axon_i  in  AXON_CNT_BIT_WIDTH  destination axon address of the packet.
REQ-008 SHALL have port pkt_ready_o  out  1  packet accepted when pkt_valid_i && pkt_ready_o on a rising edge.
REQ-009 SHALL have port step_i  in  1  single-cycle timestep-boundary request from the core controller.
REQ-010 SHALL have port spike_o  out  NUM_AXONS  committed spike vector; drives the input buffer's spike_in.
REQ-011 SHALL have port start_o  out  1  one-cycle pulse; drives the input buffer's start_i.
REQ-012 SHALL have port spkCnt_o  out  AXON_CNT_BIT_WIDTH+1  packets committed in the last timestep.
REQ-013 SHALL have port busy_o  out  1  high whenever the state is not COLLECT.
REQ-014 SHALL have port stepErr_o  out  1  sticky flag: step_i was ignored.

Function
REQ-015 SHALL hold an accumulator vector acc[NUM_AXONS-1:0], a FIFO of FIFO_DEPTH axon addresses and a packet counter cnt (AXON_CNT_BIT_WIDTH+1 bits).
REQ-016 SHALL drive pkt_ready_o = (state == COLLECT) && FIFO not full; pkt_ready_o is purely registered-state derived and does not depend on pkt_valid_i.
REQ-017 SHALL push pkt_axon_i into the FIFO on each accepted packet.
REQ-018 SHALL pop at most one FIFO entry per cycle, in COLLECT or DRAIN, whenever the FIFO is non-empty; a popped address a sets acc[NUM_AXONS-1-a] to 1 (bit order matches the buffer's [0:N-1] indexing).
REQ-019 SHALL increment cnt per popped entry, saturating at NUM_AXONS; duplicate addresses set the same bit and are still counted.
REQ-020 SHALL support simultaneous push and pop on a full FIFO only when not full at the edge (no push when full); push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged.
REQ-021 SHALL implement states COLLECT, DRAIN and COMMIT; reset state is COLLECT.
REQ-022 COLLECT: step_i=1 -> DRAIN next cycle; packets accepted in the same cycle as step_i are still pushed and belong to the current timestep.
REQ-023 DRAIN: pkt_ready_o=0; the state remains while the FIFO is non-empty after this cycle's pop; it goes to COMMIT when the FIFO is empty.
REQ-024 COMMIT (exactly one cycle): at its closing edge spike_o <= acc, spkCnt_o <= cnt, acc <= 0, cnt <= 0, start_o <= 1, state <= COLLECT.
REQ-025 SHALL assert start_o for exactly the one cycle following COMMIT; spike_o is already stable in that cycle and holds until the next COMMIT.
REQ-026 Latency: packet accepted at edge t is popped at edge t+1; its bit is set in acc after edge t+1. With an empty FIFO, step_i at edge t -> DRAIN after t -> COMMIT after t+1 -> start_o high after t+2.
REQ-027 step_i while busy_o=1 SHALL be ignored and SHALL set stepErr_o=1 until reset.
REQ-028 A timestep with no packets SHALL still commit: spike_o = 0, spkCnt_o = 0, start_o pulsed.

Reset
REQ-029 rst_i=1 at a rising edge SHALL set state=COLLECT, FIFO empty, acc=0, cnt=0, spike_o=0, spkCnt_o=0, start_o=0, stepErr_o=0, and pkt_ready_o=1 in the following cycle.
REQ-030 Reset mid-DRAIN or mid-COMMIT SHALL discard queued packets and the pending commit; start_o SHALL NOT pulse.

Verification
REQ-031 Reset then idle: all outputs 0, pkt_ready_o=1, busy_o=0.
REQ-032 Send axons 0, 5, 255, then step_i -> one start_o pulse; spike_o has only bits 255, 250 and 0 set; spkCnt_o=3.
REQ-033 Send axon 7 three times, then step -> only spike_o[248] is set; spkCnt_o=3. A second empty step -> spike_o=0, spkCnt_o=0, start_o pulsed.
REQ-034 Hold pkt_valid_i high for 10 cycles with FIFO_DEPTH=4 and step_i asserted in the 6th cycle -> pkt_ready_o low during DRAIN; all accepted packets are committed; unaccepted packets appear in the next timestep.
REQ-035 step_i during DRAIN -> stepErr_o=1 and stays 1; exactly one start_o pulse occurs.
REQ-036 rst_i asserted in the DRAIN cycle -> no start_o pulse; spike_o=0; the next step with axon 1 gives only spike_o[254] set.

Source files
------------

// File: rtl/in_spike_collector_if.sv
// Packet handshake between the spike router and the input spike collector.
interface in_spike_collector_if #(
  parameter int AXON_CNT_BIT_WIDTH = 8
);
  logic                          pkt_valid_i;
  logic [AXON_CNT_BIT_WIDTH-1:0] pkt_axon_i;
  logic                          pkt_ready_o;

  modport master (output pkt_valid_i, output pkt_axon_i, input pkt_ready_o);
  modport slave  (input pkt_valid_i, input pkt_axon_i, output pkt_ready_o);
endinterface

// File: rtl/in_spike_collector.sv
// Collects incoming spike packets into an axon vector and commits it to the
// input buffer once per timestep, after draining the packet FIFO.
module in_spike_collector #(
  parameter int NUM_AXONS          = 256,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  in_spike_collector_if.slave           pkt,
  input  logic                          step_i,
  output logic [NUM_AXONS-1:0]          spike_o,
  output logic                          start_o,
  output logic [AXON_CNT_BIT_WIDTH:0]   spkCnt_o,
  output logic                          busy_o,
  output logic                          stepErr_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [AXON_CNT_BIT_WIDTH:0] CNT_MAX = (AXON_CNT_BIT_WIDTH+1)'(NUM_AXONS);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  typedef enum logic [1:0] {COLLECT, DRAIN, COMMIT} state_t;

  state_t                        state;
  logic [AXON_CNT_BIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]                wr_ptr;
  logic [PTR_W:0]                rd_ptr;
  logic [PTR_W:0]                occupancy;
  logic [NUM_AXONS-1:0]          acc;
  logic [AXON_CNT_BIT_WIDTH:0]   cnt;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          push;
  logic                          pop;
  logic                          drain_done;
  logic [AXON_CNT_BIT_WIDTH-1:0] head;
  logic [AXON_CNT_BIT_WIDTH-1:0] acc_idx;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occupancy  = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pkt.pkt_ready_o = (state == COLLECT) && !fifo_full;
  assign push            = pkt.pkt_valid_i && pkt.pkt_ready_o;
  assign pop             = !fifo_empty && (state != COMMIT);
  assign drain_done      = (occupancy == {{PTR_W{1'b0}}, pop});
  assign busy_o          = (state != COLLECT);

  // Buffer indexes axons [0:N-1], so axon a lands on bit N-1-a, i.e. ~a.
  assign head    = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign acc_idx = ~head;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= pkt.pkt_axon_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= COLLECT;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      acc       <= '0;
      cnt       <= '0;
      spike_o   <= '0;
      spkCnt_o  <= '0;
      start_o   <= 1'b0;
      stepErr_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        acc[acc_idx] <= 1'b1;
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (step_i && (state != COLLECT)) begin
        stepErr_o <= 1'b1;
      end
      case (state)
        COLLECT: if (step_i) state <= DRAIN;
        DRAIN:   if (drain_done) state <= COMMIT;
        COMMIT: begin
          spike_o  <= acc;
          spkCnt_o <= cnt;
          acc      <= '0;
          cnt      <= '0;
          start_o  <= 1'b1;
          state    <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_in_spike_collector.sv
// Bench for in_spike_collector: table-driven timesteps, directed corner
// sequences and random traffic, all checked against a queue-based model.
module tb_in_spike_collector;

  localparam int NA = 256;
  localparam int W  = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          step_i;
  logic [NA-1:0] spike_o;
  logic          start_o;
  logic [W:0]    spkCnt_o;
  logic          busy_o;
  logic          stepErr_o;

  in_spike_collector_if #(.AXON_CNT_BIT_WIDTH(W)) bus ();

  in_spike_collector #(
    .NUM_AXONS(NA),
    .AXON_CNT_BIT_WIDTH(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .pkt(bus.slave),
    .step_i(step_i),
    .spike_o(spike_o),
    .start_o(start_o),
    .spkCnt_o(spkCnt_o),
    .busy_o(busy_o),
    .stepErr_o(stepErr_o)
  );

  always #5 clk = ~clk;

  typedef enum {M_COL, M_DRN, M_CMT} mphase_t;
  typedef struct {
    int            n;
    int            axons[4];
    int            expCnt;
    logic [NA-1:0] expSpike;
  } vec_t;

  int            nVec = 0;
  int            nErr = 0;
  int            q[$];
  mphase_t       mPhase;
  logic [NA-1:0] mAcc;
  logic [NA-1:0] mSpike;
  int            mCnt;
  int            mSpkCnt;
  bit            mStart;
  bit            mErr;
  bit            mAccepted;
  vec_t          tbl[4];

  task automatic check1(input string name, input logic [NA-1:0] act, input logic [NA-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit expReady;
    expReady = (mPhase == M_COL) && (q.size() < D);
    check1("pkt_ready", NA'(bus.pkt_ready_o), NA'(expReady));
    check1("start", NA'(start_o), NA'(mStart));
    check1("busy", NA'(busy_o), NA'(mPhase != M_COL));
    check1("stepErr", NA'(stepErr_o), NA'(mErr));
    check1("spkCnt", NA'(spkCnt_o), NA'(mSpkCnt));
    check1("spike", spike_o, mSpike);
  endtask

  // One clock cycle: drive inputs, advance the reference model, compare.
  task automatic applyStimulus(input bit v, input int a, input bit s, input bit r);
    bit mReady;
    int headAxon;
    bus.pkt_valid_i = v;
    bus.pkt_axon_i  = a[W-1:0];
    step_i          = s;
    rst_i           = r;
    mReady = (mPhase == M_COL) && (q.size() < D);
    @(posedge clk);
    mAccepted = 0;
    mStart    = 0;
    if (r) begin
      q.delete();
      mPhase  = M_COL;
      mAcc    = '0;
      mCnt    = 0;
      mSpike  = '0;
      mSpkCnt = 0;
      mErr    = 0;
    end else begin
      if ((mPhase != M_CMT) && (q.size() > 0)) begin
        headAxon = q.pop_front();
        mAcc[NA-1-headAxon] = 1'b1;
        if (mCnt < NA) mCnt++;
      end
      if (v && mReady) begin
        q.push_back(a);
        mAccepted = 1;
      end
      if (s && (mPhase != M_COL)) mErr = 1;
      case (mPhase)
        M_COL: if (s) mPhase = M_DRN;
        M_DRN: if (q.size() == 0) mPhase = M_CMT;
        M_CMT: begin
          mSpike  = mAcc;
          mSpkCnt = mCnt;
          mAcc    = '0;
          mCnt    = 0;
          mStart  = 1;
          mPhase  = M_COL;
        end
        default: mPhase = M_COL;
      endcase
    end
    #1;
    checkOutput();
  endtask

  task automatic runUntilStart(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (start_o === 1'b1) seen = 1;
    end
    check1({name, "_start_seen"}, NA'(seen), NA'(1));
  endtask

  task automatic setVec(input int idx, input int n, input int a0, input int a1,
                        input int a2, input int a3, input int cnt, input logic [NA-1:0] sp);
    tbl[idx].n        = n;
    tbl[idx].axons[0] = a0;
    tbl[idx].axons[1] = a1;
    tbl[idx].axons[2] = a2;
    tbl[idx].axons[3] = a3;
    tbl[idx].expCnt   = cnt;
    tbl[idx].expSpike = sp;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NA-1:0] one;
    logic [NA-1:0] expSp;
    int            nextAxon;
    int            starts;
    bit            rv;
    bit            rs;
    bit            rr;
    int            ra;

    one = NA'(1);
    setVec(0, 3, 0, 5, 255, 0, 3, (one << 255) | (one << 250) | one);
    setVec(1, 3, 7, 7, 7, 0, 3, one << 248);
    setVec(2, 0, 0, 0, 0, 0, 0, '0);
    setVec(3, 4, 1, 2, 254, 3, 4, (one << 254) | (one << 253) | (one << 1) | (one << 252));

    bus.pkt_valid_i = 1'b0;
    bus.pkt_axon_i  = '0;
    step_i          = 1'b0;
    rst_i           = 1'b1;
    mPhase = M_COL; mAcc = '0; mCnt = 0; mSpike = '0; mSpkCnt = 0; mErr = 0; mStart = 0;

    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    check1("reset_ready", NA'(bus.pkt_ready_o), NA'(1));
    check1("reset_busy", NA'(busy_o), NA'(0));
    check1("reset_spike", spike_o, '0);

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < tbl[t].n; k++) applyStimulus(1, tbl[t].axons[k], 0, 0);
      applyStimulus(0, 0, 1, 0);
      runUntilStart("table");
      check1("table_spike", spike_o, tbl[t].expSpike);
      check1("table_spkCnt", NA'(spkCnt_o), NA'(tbl[t].expCnt));
    end

    // Sender holds each packet until accepted; step lands in the 6th cycle.
    nextAxon = 10;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1, nextAxon, c == 6, 0);
      if (mAccepted) nextAxon++;
    end
    applyStimulus(0, 0, 0, 0);
    expSp = '0;
    for (int a = 10; a <= 15; a++) expSp[NA-1-a] = 1'b1;
    check1("hold_spike", spike_o, expSp);
    check1("hold_spkCnt", NA'(spkCnt_o), NA'(6));
    applyStimulus(0, 0, 1, 0);
    runUntilStart("hold_next");
    check1("hold_next_spike", spike_o, (one << (NA-1-16)) | (one << (NA-1-17)));
    check1("hold_next_spkCnt", NA'(spkCnt_o), NA'(2));

    for (int i = 0; i < 260; i++) applyStimulus(1, i % NA, 0, 0);
    applyStimulus(0, 0, 1, 0);
    runUntilStart("sat");
    check1("sat_spkCnt", NA'(spkCnt_o), NA'(256));
    check1("sat_spike", spike_o, '1);

    applyStimulus(1, 3, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    check1("err_set", NA'(stepErr_o), NA'(1));
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (start_o === 1'b1) starts++;
    end
    check1("err_one_start", NA'(starts), NA'(1));
    check1("err_sticky", NA'(stepErr_o), NA'(1));
    check1("err_spike", spike_o, one << 252);

    applyStimulus(1, 9, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (start_o === 1'b1) starts++;
    end
    check1("rstdrain_no_start", NA'(starts), NA'(0));
    check1("rstdrain_spike", spike_o, '0);
    check1("rstdrain_err", NA'(stepErr_o), NA'(0));
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    runUntilStart("rstdrain_next");
    check1("rstdrain_next_spike", spike_o, one << 254);

    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 9) < 6);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NA-1));
      rs = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 249) == 0);
      applyStimulus(rv, ra, rs, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
